// File: rtl/nf_cmp_2_if.sv
// Handshake bundle for the nf_cmp_2 share compressor: term vector in, compressed shares out.
// The master drives terms and accepts shares; the slave is the compressor itself.
interface nf_cmp_2_if #(
    parameter int unsigned CNT_W = 8
);
    logic [26:0]      q_in;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       out_sh;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output q_in, in_valid, out_ready,
        input  in_ready, out_sh, out_valid, beat_cnt
    );

    modport slave (
        input  q_in, in_valid, out_ready,
        output in_ready, out_sh, out_valid, beat_cnt
    );
endinterface

// File: rtl/nf_cmp_2.sv
// Two-stage share compressor: registers the 27 nonlinear terms as a glitch barrier, then XORs
// each 3-bit group into one output share. Fully pipelined with valid/ready on both sides.
module nf_cmp_2 #(
    parameter int unsigned CNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    nf_cmp_2_if.slave  bus
);

    logic [26:0]      t_q, t_d;
    logic             vt_q, vt_d;
    logic [8:0]       s_q, s_d;
    logic             vs_q, vs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       in_xfer;
    logic       out_xfer;
    logic       s_load;
    logic       in_rdy;
    logic [8:0] comp;

    // Each share only ever combines the three registered terms of its own group.
    always_comb begin
        comp = '0;
        for (int i = 0; i < 9; i++) begin
            comp[i] = ^t_q[3*i +: 3];
        end
    end

    always_comb begin
        s_load   = vt_q & (~vs_q | bus.out_ready);
        in_rdy   = ~vt_q | ~vs_q | bus.out_ready;
        in_xfer  = bus.in_valid & in_rdy;
        out_xfer = vs_q & bus.out_ready;

        t_d   = t_q;
        vt_d  = vt_q;
        s_d   = s_q;
        vs_d  = vs_q;
        cnt_d = cnt_q;

        if (in_xfer) begin
            t_d  = bus.q_in;
            vt_d = 1'b1;
        end else if (s_load) begin
            vt_d = 1'b0;
        end

        if (s_load) begin
            s_d  = comp;
            vs_d = 1'b1;
        end else if (out_xfer) begin
            vs_d = 1'b0;
        end

        if (out_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q   <= '0;
            vt_q  <= 1'b0;
            s_q   <= '0;
            vs_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            t_q   <= t_d;
            vt_q  <= vt_d;
            s_q   <= s_d;
            vs_q  <= vs_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vs_q;
    assign bus.out_sh    = s_q;
    assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_nf_cmp_2.sv
// Scoreboard bench for nf_cmp_2: accepted inputs push model results, a monitor pops on each
// output handshake. Directed corner cases plus randomized valid/ready traffic.
module tb_nf_cmp_2;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nf_cmp_2_if #(.CNT_W(CW)) bus ();

    nf_cmp_2 #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int exp_cnt = 0;

    // Share = parity of the three terms in its group.
    function automatic logic [8:0] ref_share(input logic [26:0] q);
        logic [8:0] r;
        logic [2:0] g;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            for (int s = 1; s <= 3; s++) begin
                g = 3'((q >> (9 * k + 3 * (s - 1))) & 27'd7);
                r[3 * k + s - 1] = ($countones(g) % 2) == 1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single vector with out_ready high: visible exactly two cycles after acceptance, then gone.
    task automatic single(input string name, input logic [26:0] q, input logic [8:0] exp);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.q_in      = q;
        step();
        bus.in_valid = 1'b0;
        bus.q_in     = 27'($urandom);
        chk({name, " early"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({name, " valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, " sh"}, 32'(bus.out_sh), 32'(exp));
        step();
        chk({name, " drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Stimulus side of the scoreboard: every accepted vector queues its expected shares.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(ref_share(bus.q_in));
        end
    end

    initial begin
        logic       stall;
        logic [8:0] prev_sh;
        stall   = 1'b0;
        prev_sh = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk("hold valid", 32'(bus.out_valid), 32'd1);
                chk("hold sh", 32'(bus.out_sh), 32'(prev_sh));
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb extra: got %0h expected no output", bus.out_sh);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if (bus.out_sh !== e) begin
                        errors++;
                        $display("FAIL sb data: got %0h expected %0h", bus.out_sh, e);
                    end
                end
                chk("sb cnt", 32'(bus.beat_cnt), 32'(exp_cnt % 16));
                exp_cnt++;
            end
            stall   = bus.out_valid && !bus.out_ready;
            prev_sh = bus.out_sh;
        end
    end

    initial begin
        logic [26:0] a, b, c;
        bus.in_valid  = 1'b0;
        bus.q_in      = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst beat_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_sh", 32'(bus.out_sh), 32'd0);
        step();
        step();
        rst = 1'b0;

        single("single", 27'h0000007, 9'h001);
        chk("single cnt", 32'(bus.beat_cnt), 32'd1);
        single("corner ones", 27'h7FFFFFF, 9'h1FF);
        single("corner 3", 27'h0000003, 9'h000);
        single("corner ends", 27'h4000001, 9'h101);

        // Fill both stages under backpressure, hold, then release.
        a = 27'($urandom);
        b = 27'($urandom);
        c = 27'($urandom);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.q_in      = a;
        step();
        bus.q_in = b;
        step();
        bus.q_in = c;
        chk("bp in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp first", 32'(bus.out_sh), 32'(ref_share(a)));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp hold ready", 32'(bus.in_ready), 32'd0);
            chk("bp hold sh", 32'(bus.out_sh), 32'(ref_share(a)));
        end
        bus.out_ready = 1'b1;
        chk("bp release a", 32'(bus.out_sh), 32'(ref_share(a)));
        step();
        bus.in_valid = 1'b0;
        chk("bp release b v", 32'(bus.out_valid), 32'd1);
        chk("bp release b", 32'(bus.out_sh), 32'(ref_share(b)));
        step();
        chk("bp release c v", 32'(bus.out_valid), 32'd1);
        chk("bp release c", 32'(bus.out_sh), 32'(ref_share(c)));
        step();
        chk("bp empty", 32'(bus.out_valid), 32'd0);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.q_in      = 27'($urandom);
        step();
        bus.q_in = 27'($urandom);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst beat_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst stale", 32'(bus.out_valid), 32'd0);
        end

        // 17 transfers on a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.q_in     = 27'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("wrap cnt", 32'(bus.beat_cnt), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.q_in      = 27'($urandom);
            bus.out_ready = ($urandom % 3) != 0;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain queue", 32'(exp_q.size()), 32'd0);
        chk("drain cnt", 32'(bus.beat_cnt), 32'(exp_cnt % 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
